bcd_convert_sched: RTL

- Time-shared, iterative binary-to-BCD conversion engine for the on-screen numeric displays (score, high score / lives).
- Two requesters share one shift-add-3 (double-dabble) datapath that processes one bit per clock.
- Round-robin arbitration sequences conversions and returns 3 BCD digits tagged with the owner.
- Replaces per-display combinational converters with one small, multi-cycle shared unit.

---
 rtl/bcd_convert_sched.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/bcd_convert_sched.sv
// Shared iterative binary-to-BCD converter (double-dabble, one bit per clock) for two round-robin requesters.
// Optional per-requester result cache enabled by defining BCD_RESULT_CACHE_EN.
module bcd_convert_sched #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] bin0,
    input  logic [WIDTH-1:0] bin1,
    output logic [1:0]       ack,
    output logic             busy,
    output logic             out_valid,
    output logic             out_id,
    output logic [3:0]       hundreds,
    output logic [3:0]       tens,
    output logic [3:0]       ones
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [3:0] CNT_INIT = 4'(WIDTH - 1);

    logic [1:0]          state;
    logic                last_served;
    logic [WIDTH-1:0]    sreg;
    logic [11:0]         acc;
    logic [3:0]          cnt;

    logic                winner;
    logic [WIDTH-1:0]    win_bin;
    logic [11:0]         acc_adj;
    logic [11+WIDTH:0]   shifted;
    logic                hit;
    logic [11:0]         hit_bcd;

`ifdef BCD_RESULT_CACHE_EN
    logic [1:0]              cache_valid;
    logic [1:0][WIDTH-1:0]   cache_bin;
    logic [1:0][11:0]        cache_bcd;
    logic [WIDTH-1:0]        cap_bin;

    assign hit     = cache_valid[winner] && (cache_bin[winner] == win_bin);
    assign hit_bcd = cache_bcd[winner];
`else
    assign hit     = 1'b0;
    assign hit_bcd = '0;
`endif

    assign busy = (state != IDLE);

    // On a tie the requester not served last wins; a lone requester always wins.
    always_comb begin
        winner = 1'b0;
        if (req == 2'b10) begin
            winner = 1'b1;
        end else if (req == 2'b11) begin
            winner = ~last_served;
        end
        win_bin = winner ? bin1 : bin0;
    end

    // Add-3 correction on every nibble >= 5 before the shift.
    always_comb begin
        acc_adj = acc;
        for (int unsigned i = 0; i < 3; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
        shifted = {acc_adj, sreg} << 1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            last_served <= 1'b1;
            ack         <= '0;
            out_valid   <= 1'b0;
            out_id      <= 1'b0;
            hundreds    <= '0;
            tens        <= '0;
            ones        <= '0;
            sreg        <= '0;
            acc         <= '0;
            cnt         <= '0;
`ifdef BCD_RESULT_CACHE_EN
            cache_valid <= '0;
            cache_bin   <= '0;
            cache_bcd   <= '0;
            cap_bin     <= '0;
`endif
        end else begin
            ack       <= '0;
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        sreg        <= win_bin;
                        acc         <= hit ? hit_bcd : 12'd0;
                        cnt         <= CNT_INIT;
                        ack[winner] <= 1'b1;
                        last_served <= winner;
                        out_id      <= winner;
                        state       <= hit ? DONE : SHIFT;
`ifdef BCD_RESULT_CACHE_EN
                        cap_bin     <= win_bin;
`endif
                    end
                end
                SHIFT: begin
                    acc  <= shifted[11+WIDTH:WIDTH];
                    sreg <= shifted[WIDTH-1:0];
                    if (cnt == 4'd0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    hundreds  <= acc[11:8];
                    tens      <= acc[7:4];
                    ones      <= acc[3:0];
                    out_valid <= 1'b1;
                    state     <= IDLE;
`ifdef BCD_RESULT_CACHE_EN
                    // A hit rewrites the same entry, so no hit/miss distinction is needed here.
                    cache_valid[out_id] <= 1'b1;
                    cache_bin[out_id]   <= cap_bin;
                    cache_bcd[out_id]   <= acc;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
